mem_access_unit: RTL and testbench

- Parametrised load/store sequencer between the LEGv8 datapath and the RAM_64bit array; replaces direct control-word driving of chip_select/write_enable/read_enable/size.
- Accepts one load or store request per handshake and drives the RAM strobes for a configurable number of wait states.
- Checks alignment and size legality, returns loaded data zero- or sign-extended to DATA_WIDTH, and signals busy/done/fault back to the control unit.

---
 rtl/mem_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : mem_access_unit                                          |
// | Description : Load/store sequencer between the LEGv8 datapath and the  |
// |               RAM_64bit array. Accepts one request per start strobe,   |
// |               holds the RAM strobes for WAIT_STATES+1 cycles, checks   |
// |               alignment/size legality and returns extended load data.  |
// | Ports       : clock/reset (async, active-low); start, write,           |
// |               sign_extend, size, address_in, store_data (request);     |
// |               load_data, busy, done, fault (status to control unit);   |
// |               mem_* (RAM address, data and strobes).                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  write,
    input  logic                  sign_extend,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_chip_select,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    output logic [1:0]            mem_size
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_STATES);

    state_t                  state_q, state_d;
    logic                    write_q, write_d;
    logic                    sext_q, sext_d;
    logic [1:0]              size_q, size_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              count_q, count_d;
    logic                    fault_q, fault_d;
    logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;

    logic                    misaligned;
    logic                    illegal;
    logic                    sign_bit;
    logic [DATA_WIDTH-1:0]   rd_mask;
    logic [DATA_WIDTH-1:0]   rd_ext;

    // Low 8*2^sz bits set; everything above is the extension/masking region.
    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   lane_mask = DATA_WIDTH'(64'h0000_0000_0000_00FF);
            2'b01:   lane_mask = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
            2'b10:   lane_mask = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
            default: lane_mask = {DATA_WIDTH{1'b1}};
        endcase
    endfunction

    // Request legality is judged on the live inputs in the accepting cycle.
    always_comb begin
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = address_in[0];
            2'b10:   misaligned = |address_in[1:0];
            default: misaligned = |address_in[2:0];
        endcase
        illegal = misaligned | ((size == 2'b11) && (DATA_WIDTH == 32));
    end

    // Extension of the right-justified read data using the latched size.
    always_comb begin
        case (size_q)
            2'b00:   sign_bit = mem_rdata[7];
            2'b01:   sign_bit = mem_rdata[15];
            2'b10:   sign_bit = mem_rdata[31];
            default: sign_bit = mem_rdata[DATA_WIDTH-1];
        endcase
        rd_mask = lane_mask(size_q);
        // A full-width load has an all-ones mask, so no extension bits remain.
        rd_ext  = (mem_rdata & rd_mask) |
                  ({DATA_WIDTH{sext_q & sign_bit}} & ~rd_mask);
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        sext_d      = sext_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        count_d     = count_q;
        fault_d     = fault_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    write_d = write;
                    sext_d  = sign_extend;
                    size_d  = size;
                    addr_d  = address_in;
                    wdata_d = store_data & lane_mask(size);
                    fault_d = illegal;
                    if (illegal) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCESS;
                        count_d = C_WAIT_INIT;
                    end
                end
            end
            ACCESS: begin
                // Counter reaching zero marks the final strobe cycle.
                if (count_q == 4'd0) begin
                    if (!write_q) begin
                        load_data_d = rd_ext;
                    end
                    state_d = DONE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            sext_q      <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            count_q     <= 4'd0;
            fault_q     <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            sext_q      <= sext_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
        end
    end

    // Strobes decode from the state register alone, so an asynchronous
    // reset drops them without waiting for a clock edge.
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign fault            = (state_q == DONE) & fault_q;
    assign mem_chip_select  = (state_q == ACCESS);
    assign mem_write_enable = (state_q == ACCESS) & write_q;
    assign mem_read_enable  = (state_q == ACCESS) & ~write_q;
    assign mem_wdata        = ((state_q == ACCESS) && write_q) ? wdata_q : '0;
    assign mem_address      = addr_q;
    assign mem_size         = size_q;
    assign load_data        = load_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_mem_access_unit                                       |
// | Description : Scoreboard bench for mem_access_unit. Two instances run  |
// |               side by side (WAIT_STATES = 0 and 3) on shared request   |
// |               inputs with private start strobes. Stimulus pushes the   |
// |               expected completion; monitors pop on each done pulse.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_mem_access_unit;

    localparam int DW = 64;
    localparam int AW = 16;

    typedef struct {
        int          due;
        logic        fault;
        logic [63:0] ld;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start0 = 1'b0;
    logic          start3 = 1'b0;
    logic          write = 1'b0;
    logic          sign_extend = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [AW-1:0] address_in = '0;
    logic [DW-1:0] store_data = '0;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] load_data_0, load_data_3, mem_wdata_0, mem_wdata_3;
    logic [AW-1:0] mem_address_0, mem_address_3;
    logic          busy_0, done_0, fault_0, cs_0, we_0, re_0;
    logic          busy_3, done_3, fault_3, cs_3, we_3, re_3;
    logic [1:0]    mem_size_0, mem_size_3;

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    exp_t          q0[$];
    exp_t          q3[$];
    exp_t          e0, e3;
    logic [63:0]   last0 = '0;
    logic [63:0]   last3 = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(reset), .start(start0), .write(write),
        .sign_extend(sign_extend), .size(size), .address_in(address_in),
        .store_data(store_data), .load_data(load_data_0), .busy(busy_0),
        .done(done_0), .fault(fault_0), .mem_address(mem_address_0),
        .mem_wdata(mem_wdata_0), .mem_rdata(mem_rdata),
        .mem_chip_select(cs_0), .mem_write_enable(we_0),
        .mem_read_enable(re_0), .mem_size(mem_size_0)
    );

    mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset(reset), .start(start3), .write(write),
        .sign_extend(sign_extend), .size(size), .address_in(address_in),
        .store_data(store_data), .load_data(load_data_3), .busy(busy_3),
        .done(done_3), .fault(fault_3), .mem_address(mem_address_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata),
        .mem_chip_select(cs_3), .mem_write_enable(we_3),
        .mem_read_enable(re_3), .mem_size(mem_size_3)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (done_0) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ws0_unexpected_done: actual done=1 required no pending request (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                check("ws0_done_cycle", 64'(cyc), 64'(e0.due));
                check("ws0_fault", 64'(fault_0), 64'(e0.fault));
                check("ws0_load_data", load_data_0, e0.ld);
            end
        end
    end

    always @(negedge clock) begin
        if (done_3) begin
            if (q3.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ws3_unexpected_done: actual done=1 required no pending request (cycle %0d)", cyc);
            end else begin
                e3 = q3.pop_front();
                check("ws3_done_cycle", 64'(cyc), 64'(e3.due));
                check("ws3_fault", 64'(fault_3), 64'(e3.fault));
                check("ws3_load_data", load_data_3, e3.ld);
            end
        end
    end

    // Drives one request for a full cycle and returns at the negedge of the
    // cycle after acceptance (the first ACCESS cycle of a legal request).
    task automatic issue(input int k, input logic w, input logic se, input logic [1:0] sz,
                         input logic [15:0] a, input logic [63:0] d, input logic [63:0] rd,
                         input logic flt, input logic [63:0] ld, input bit push);
        exp_t e;
        @(negedge clock);
        write       = w;
        sign_extend = se;
        size        = sz;
        address_in  = a;
        store_data  = d;
        mem_rdata   = rd;
        if (k == 0) start0 = 1'b1;
        else        start3 = 1'b1;
        e.fault = flt;
        e.due   = cyc + (flt ? 1 : ((k == 0) ? 2 : 5));
        if (k == 0) e.ld = (flt || w) ? last0 : ld;
        else        e.ld = (flt || w) ? last3 : ld;
        if (push) begin
            if (k == 0) begin
                q0.push_back(e);
                last0 = e.ld;
            end else begin
                q3.push_back(e);
                last3 = e.ld;
            end
        end
        @(negedge clock);
        start0 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (((k == 0) ? (busy_0 | done_0) : (busy_3 | done_3)) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ws%0d_idle_timeout: actual busy after 40 cycles required idle", k);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        check("rst_flags_0", 64'({busy_0, done_0, fault_0, cs_0, we_0, re_0, mem_size_0}), 64'd0);
        check("rst_flags_3", 64'({busy_3, done_3, fault_3, cs_3, we_3, re_3, mem_size_3}), 64'd0);
        check("rst_addr_0", 64'(mem_address_0), 64'd0);
        check("rst_wdata_0", mem_wdata_0, 64'd0);
        check("rst_load_0", load_data_0, 64'd0);
        check("rst_load_3", load_data_3, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // 64-bit store, zero wait states
        issue(0, 1'b1, 1'b0, 2'b11, 16'h0008, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 64'd0, 1'b1);
        check("st64_strobes", 64'({cs_0, we_0, re_0}), 64'b110);
        check("st64_wdata", mem_wdata_0, 64'h1122_3344_5566_7788);
        check("st64_addr", 64'(mem_address_0), 64'h0008);
        check("st64_size", 64'(mem_size_0), 64'd3);
        check("st64_busy", 64'(busy_0), 64'd1);
        @(negedge clock);
        check("st64_done_strobes", 64'({cs_0, we_0, re_0, mem_wdata_0 != 64'd0}), 64'd0);
        check("st64_done_busy", 64'(busy_0), 64'd1);

        // Back-to-back byte load, sign extended (issued in first IDLE cycle)
        issue(0, 1'b0, 1'b1, 2'b00, 16'h0011, 64'd0, 64'hABCD_0000_1234_5680, 1'b0,
              64'hFFFF_FFFF_FFFF_FF80, 1'b1);
        check("ldb_strobes", 64'({cs_0, we_0, re_0}), 64'b101);
        check("ldb_wdata_idle", mem_wdata_0, 64'd0);
        wait_idle(0);
        issue(0, 1'b0, 1'b0, 2'b00, 16'h0011, 64'd0, 64'hABCD_0000_1234_5680, 1'b0,
              64'h0000_0000_0000_0080, 1'b1);
        wait_idle(0);
        issue(0, 1'b0, 1'b1, 2'b01, 16'h0002, 64'd0, 64'h1234_5678_9ABC_8001, 1'b0,
              64'hFFFF_FFFF_FFFF_8001, 1'b1);
        wait_idle(0);
        issue(0, 1'b0, 1'b1, 2'b10, 16'h000C, 64'd0, 64'hFFFF_FFFF_7000_0001, 1'b0,
              64'h0000_0000_7000_0001, 1'b1);
        wait_idle(0);
        // Byte store: write data masked to the low lane
        issue(0, 1'b1, 1'b0, 2'b00, 16'h0005, 64'hFFEE_DDCC_BBAA_9988, 64'd0, 1'b0, 64'd0, 1'b1);
        check("stb_wdata_mask", mem_wdata_0, 64'h0000_0000_0000_0088);
        wait_idle(0);
        // Misaligned doubleword: fault, memory untouched
        issue(0, 1'b0, 1'b1, 2'b11, 16'h0004, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1);
        check("fault64_no_cs", 64'({cs_0, we_0, re_0}), 64'd0);
        wait_idle(0);
        issue(0, 1'b0, 1'b1, 2'b11, 16'h0018, 64'd0, 64'h8000_0000_0000_0001, 1'b0,
              64'h8000_0000_0000_0001, 1'b1);
        wait_idle(0);

        // Three wait states: word load
        issue(3, 1'b0, 1'b0, 2'b10, 16'h0004, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0,
              64'h0000_0000_CAFE_F00D, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ws3_access_c%0d", i), 64'({cs_3, re_3, we_3, busy_3}), 64'b1101);
            @(negedge clock);
        end
        check("ws3_done_c5", 64'({cs_3, re_3, busy_3}), 64'b001);
        wait_idle(3);

        // Misaligned halfword: immediate fault, load_data unchanged
        issue(3, 1'b0, 1'b1, 2'b01, 16'h0003, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1);
        check("ws3_fault_no_cs", 64'({cs_3, we_3, re_3}), 64'd0);
        check("ws3_fault_addr", 64'(mem_address_3), 64'h0003);
        wait_idle(3);

        // start during ACCESS is ignored
        issue(3, 1'b1, 1'b0, 2'b01, 16'h0010, 64'hAAAA_0000_0000_BEEF, 64'd0, 1'b0, 64'd0, 1'b1);
        check("ws3_st16_wdata", mem_wdata_3, 64'h0000_0000_0000_BEEF);
        @(negedge clock);
        start3     = 1'b1;
        address_in = 16'h0200;
        @(negedge clock);
        check("ws3_ignore_addr_c3", 64'(mem_address_3), 64'h0010);
        start3 = 1'b0;
        @(negedge clock);
        check("ws3_ignore_addr_c4", 64'(mem_address_3), 64'h0010);
        check("ws3_ignore_we_c4", 64'(we_3), 64'd1);
        wait_idle(3);

        // Reset in the second ACCESS cycle aborts with no done pulse
        issue(3, 1'b0, 1'b0, 2'b11, 16'h0020, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_strobes", 64'({cs_3, we_3, re_3, busy_3, done_3}), 64'd0);
        check("abort_load_3", load_data_3, 64'd0);
        check("abort_load_0", load_data_0, 64'd0);
        last0 = '0;
        last3 = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_no_done", 64'(done_3), 64'd0);

        // Normal operation resumes after reset
        issue(3, 1'b0, 1'b1, 2'b00, 16'h0007, 64'd0, 64'hFFFF_FFFF_FFFF_FF7F, 1'b0,
              64'h0000_0000_0000_007F, 1'b1);
        wait_idle(3);
        issue(0, 1'b0, 1'b0, 2'b01, 16'h0006, 64'd0, 64'hFFFF_FFFF_FFFF_F234, 1'b0,
              64'h0000_0000_0000_F234, 1'b1);
        wait_idle(0);

        // Drain: every expected completion must have been observed
        for (int i = 0; i < 20 && (q0.size() != 0 || q3.size() != 0); i++) begin
            @(negedge clock);
        end
        check("pending_ws0", 64'(q0.size()), 64'd0);
        check("pending_ws3", 64'(q3.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
